// File: rtl/ov7670_frame_capture.sv
// OV7670 capture: decimates RGB565 by 2^DECIM_SHIFT on both axes into RGB332 and writes one frame to block RAM.
// Optional OV7670_CAPTURE_TEST_PATTERN_EN: write data becomes Wr_Addr_o[7:0] for a deterministic RAM image.
module ov7670_frame_capture #(
  parameter int SRC_WIDTH   = 640,
  parameter int SRC_HEIGHT  = 480,
  parameter int DECIM_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              Vsync_i,
  input  logic              Href_i,
  input  logic [7:0]        Data_i,
  input  logic              Mem_Ack_i,
  output logic              Wr_En_o,
  output logic [ADDR_W-1:0] Wr_Addr_o,
  output logic [7:0]        Wr_Data_o,
  output logic              Frame_Available_o
);

  localparam int TOTAL = (SRC_WIDTH >> DECIM_SHIFT) * (SRC_HEIGHT >> DECIM_SHIFT);
  localparam logic [ADDR_W-1:0] TOTAL_C = ADDR_W'(TOTAL);
  localparam logic [9:0] WIDTH_C  = 10'(SRC_WIDTH);
  localparam logic [9:0] COL_MASK = 10'((1 << DECIM_SHIFT) - 1);
  localparam logic [8:0] ROW_MASK = 9'((1 << DECIM_SHIFT) - 1);

  typedef enum logic [1:0] {WAIT_START, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic              vs_q, vs_d, hr_q, hr_d;
  logic              vs_dly_q, vs_dly_d, hr_dly_q, hr_dly_d;
  logic [7:0]        d_q, d_d;
  logic              phase_q, phase_d;
  logic [9:0]        col_q, col_d;
  logic [8:0]        row_q, row_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [5:0]        byte0_q, byte0_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic vs_rise, vs_fall, hr_rise, hr_fall, cur_phase, keep;

  assign vs_rise   = vs_q & ~vs_dly_q;
  assign vs_fall   = ~vs_q & vs_dly_q;
  assign hr_rise   = hr_q & ~hr_dly_q;
  assign hr_fall   = ~hr_q & hr_dly_q;
  assign cur_phase = hr_rise ? 1'b0 : phase_q;
  assign keep      = (state_q == CAPTURE) && hr_q && cur_phase &&
                     (col_q < WIDTH_C) && ((col_q & COL_MASK) == 10'd0) &&
                     ((row_q & ROW_MASK) == 9'd0) && (cnt_q < TOTAL_C);

  always_comb begin
    vs_d      = Vsync_i;
    hr_d      = Href_i;
    d_d       = Data_i;
    vs_dly_d  = vs_q;
    hr_dly_d  = hr_q;
    state_d   = state_q;
    phase_d   = 1'b0;
    col_d     = 10'd0;
    row_d     = 9'd0;
    cnt_d     = cnt_q;
    byte0_d   = byte0_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (state_q == CAPTURE) begin
      phase_d = hr_q ? ~cur_phase : 1'b0;
      // Only the bits that survive the RGB565 -> RGB332 reduction are kept from byte 0.
      if (hr_q && !cur_phase) byte0_d = {d_q[7:5], d_q[2:0]};
      col_d = col_q;
      if (hr_rise) col_d = 10'd0;
      else if (hr_q && cur_phase && col_q != '1) col_d = col_q + 10'd1;
      row_d = row_q;
      if (hr_fall && row_q != '1) row_d = row_q + 9'd1;
      if (keep) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
        wr_data_d = cnt_q[7:0];
`else
        wr_data_d = {byte0_q, d_q[4:3]};
`endif
        cnt_d     = cnt_q + 1'b1;
      end
    end

    case (state_q)
      WAIT_START: begin
        cnt_d = '0;
        if (vs_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        // cnt_d includes a write decided this cycle, so a coincident final pixel still counts.
        if (vs_rise) state_d = (cnt_d == TOTAL_C) ? DONE : WAIT_START;
      end
      DONE: begin
        if (Mem_Ack_i) state_d = WAIT_START;
      end
      default: state_d = WAIT_START;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q   <= WAIT_START;
      vs_q      <= 1'b0;
      hr_q      <= 1'b0;
      d_q       <= 8'd0;
      vs_dly_q  <= 1'b0;
      hr_dly_q  <= 1'b0;
      phase_q   <= 1'b0;
      col_q     <= 10'd0;
      row_q     <= 9'd0;
      cnt_q     <= '0;
      byte0_q   <= 6'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_d;
      hr_q      <= hr_d;
      d_q       <= d_d;
      vs_dly_q  <= vs_dly_d;
      hr_dly_q  <= hr_dly_d;
      phase_q   <= phase_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      byte0_q   <= byte0_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign Wr_En_o           = wr_en_q;
  assign Wr_Addr_o         = wr_addr_q;
  assign Wr_Data_o         = wr_data_q;
  assign Frame_Available_o = (state_q == DONE);

endmodule
